// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM channel link (demux now, transmitter later).
package tdm_pkg;

  localparam int NUM_CH = 8;

  typedef logic [2:0] slot_t;

  localparam slot_t SLOT_LAST = 3'd7;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_demux8.sv
// Receive side of the 8-slot TDM link: locks on the slot-0 sync strobe,
// rebuilds each frame bit by bit and publishes whole frames with a valid pulse.
module tdm_demux8
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              din,
  input  logic              sync,
  output logic [NUM_CH-1:0] out,
  output logic              valid,
  output slot_t             slot,
  output logic              locked,
  output logic              sync_err
);

  state_t              state_q, state_d;
  slot_t               slot_q, slot_d;
  logic [NUM_CH-2:0]   asm_q, asm_d;
  logic [NUM_CH-1:0]   out_q, out_d;
  logic                valid_q, valid_d;
  logic                sync_err_q, sync_err_d;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    asm_d      = asm_q;
    out_d      = out_q;
    valid_d    = 1'b0;
    sync_err_d = 1'b0;

    if (en) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            asm_d   = {{(NUM_CH-2){1'b0}}, din};
            slot_d  = 3'd1;
            state_d = LOCKED;
          end
        end

        LOCKED: begin
          if (slot_q == 3'd0) begin
            if (sync) begin
              asm_d  = {{(NUM_CH-2){1'b0}}, din};
              slot_d = 3'd1;
            end else begin
              sync_err_d = 1'b1;
              slot_d     = 3'd0;
              state_d    = HUNT;
            end
          end else if (sync) begin
            // Early sync: drop the partial frame and restart on this sample.
            sync_err_d = 1'b1;
            asm_d      = {{(NUM_CH-2){1'b0}}, din};
            slot_d     = 3'd1;
          end else if (slot_q == SLOT_LAST) begin
            out_d   = {din, asm_q};
            valid_d = 1'b1;
            slot_d  = 3'd0;
          end else begin
            asm_d[slot_q] = din;
            slot_d        = slot_q + 3'd1;
          end
        end

        default: begin
          state_d = HUNT;
          slot_d  = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      slot_q     <= 3'd0;
      asm_q      <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      asm_q      <= asm_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign out      = out_q;
  assign valid    = valid_q;
  assign slot     = slot_q;
  assign locked   = (state_q == LOCKED);
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8: frame assembly, gaps, sync errors, reset and streaming.
module tb_tdm_demux8;

  logic       clk;
  logic       rst;
  logic       en;
  logic       din;
  logic       sync;
  logic [7:0] out;
  logic       valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] expOut;

  tdm_demux8 dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .din      (din),
    .sync     (sync),
    .out      (out),
    .valid    (valid),
    .slot     (slot),
    .locked   (locked),
    .sync_err (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; returns 1ns after the sampling edge.
  task automatic applyStimulus(input logic e, input logic d, input logic s);
    en   = e;
    din  = d;
    sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [7:0] data, input int gapAfter, input int gapLen);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, data[i], i == 0);
      if (i < 7) begin
        checkOutput("frame_valid_low", {7'b0, valid}, 8'h00);
        checkOutput("frame_slot", {5'b0, slot}, 8'(i + 1));
        checkOutput("frame_out_hold", out, expOut);
        checkOutput("frame_no_err", {7'b0, sync_err}, 8'h00);
        if (i == gapAfter) begin
          for (int g = 0; g < gapLen; g++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput("gap_slot", {5'b0, slot}, 8'(i + 1));
            checkOutput("gap_valid_low", {7'b0, valid}, 8'h00);
          end
        end
      end
    end
    expOut = data;
    checkOutput("frame_valid", {7'b0, valid}, 8'h01);
    checkOutput("frame_out", out, data);
    checkOutput("frame_slot_wrap", {5'b0, slot}, 8'h00);
    checkOutput("frame_locked", {7'b0, locked}, 8'h01);
  endtask

  initial begin
    logic [7:0] tail;
    rst    = 1'b1;
    en     = 1'b0;
    din    = 1'b0;
    sync   = 1'b0;
    expOut = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out", out, 8'h00);
    checkOutput("rst_valid", {7'b0, valid}, 8'h00);
    checkOutput("rst_err", {7'b0, sync_err}, 8'h00);
    checkOutput("rst_locked", {7'b0, locked}, 8'h00);
    checkOutput("rst_slot", {5'b0, slot}, 8'h00);
    rst = 1'b0;

    // Unsynced samples while hunting are ignored.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("hunt_ignore_locked", {7'b0, locked}, 8'h00);
    checkOutput("hunt_ignore_err", {7'b0, sync_err}, 8'h00);

    // Basic frame: slots 0..7 = 1,0,1,1,0,0,1,0 -> 8'h4D
    sendFrame(8'h4D, -1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("basic_valid_one_cycle", {7'b0, valid}, 8'h00);
    checkOutput("basic_out_hold", out, 8'h4D);

    // Gapped frame with 3 idle cycles between slots 3 and 4.
    sendFrame(8'h4D, 3, 3);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Missing sync at slot 0.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("miss_err", {7'b0, sync_err}, 8'h01);
    checkOutput("miss_locked", {7'b0, locked}, 8'h00);
    checkOutput("miss_out", out, 8'h4D);
    checkOutput("miss_valid", {7'b0, valid}, 8'h00);
    checkOutput("miss_slot", {5'b0, slot}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("miss_err_one_cycle", {7'b0, sync_err}, 8'h00);
    sendFrame(8'h96, -1, 0);

    // Early sync at slot 5: partial 1,1,0,0,1 then resync with din=1.
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("early_pre_slot", {5'b0, slot}, 8'h05);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("early_err", {7'b0, sync_err}, 8'h01);
    checkOutput("early_valid", {7'b0, valid}, 8'h00);
    checkOutput("early_slot", {5'b0, slot}, 8'h01);
    checkOutput("early_locked", {7'b0, locked}, 8'h01);
    checkOutput("early_out_hold", out, 8'h96);
    // Remaining bits 1..7 = 0,1,0,1,1,1,0 -> frame 8'h75
    tail = 8'h75;
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b1, tail[i], 1'b0);
      if (i < 7) checkOutput("early_fill_valid", {7'b0, valid}, 8'h00);
    end
    checkOutput("early_frame_valid", {7'b0, valid}, 8'h01);
    checkOutput("early_frame_out", out, 8'h75);
    expOut = 8'h75;

    // Reset mid-frame at slot 4.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, i == 0);
    checkOutput("midrst_pre_slot", {5'b0, slot}, 8'h04);
    rst = 1'b1;
    #1;
    checkOutput("midrst_async_out", out, 8'h00);
    checkOutput("midrst_async_slot", {5'b0, slot}, 8'h00);
    checkOutput("midrst_async_locked", {7'b0, locked}, 8'h00);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    expOut = 8'h00;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("midrst_no_valid", {7'b0, valid}, 8'h00);
      checkOutput("midrst_no_lock", {7'b0, locked}, 8'h00);
    end
    sendFrame(8'hC3, -1, 0);

    // Continuous stream of four back-to-back frames.
    sendFrame(8'hFF, -1, 0);
    sendFrame(8'h00, -1, 0);
    sendFrame(8'hA5, -1, 0);
    sendFrame(8'h3C, -1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stream_end_valid", {7'b0, valid}, 8'h00);
    checkOutput("stream_end_out", out, 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
